// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: the four control tokens (also used by the TX encoder)
// and the receive word-aligner state encoding.
package tmds_pkg;

  // Control tokens as 10-bit words, bit0 = first serial bit. Suffix is {c1,c0}.
  localparam logic [9:0] CTRL_TOKEN_0 = 10'b1101010100;
  localparam logic [9:0] CTRL_TOKEN_1 = 10'b0010101011;
  localparam logic [9:0] CTRL_TOKEN_2 = 10'b0101010100;
  localparam logic [9:0] CTRL_TOKEN_3 = 10'b1010101011;

  typedef enum logic [1:0] {
    SEARCH,
    SLIP,
    LOCKED
  } state_e;

endpackage

// File: rtl/tmds_decode_10b8b.sv
// Registered TMDS 10b->8b decoder with control-token detection, 1-cycle latency.
// Ports:
//   clk      in   clock
//   rst_n    in   asynchronous active-low reset
//   word     in   aligned 10-bit TMDS word
//   data     out  decoded byte (0 for tokens)
//   c0, c1   out  control bits of a detected token (0 otherwise)
//   is_token out  word was one of the four control tokens
module tmds_decode_10b8b
  import tmds_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] word,
  output logic [7:0] data,
  output logic       c0,
  output logic       c1,
  output logic       is_token
);

  logic [7:0] v;
  logic [7:0] data_d;
  logic       c0_d;
  logic       c1_d;
  logic       tok_d;

  always_comb begin
    // Undo the optional DC-balance inversion, then the xor/xnor chain.
    v         = word[9] ? ~word[7:0] : word[7:0];
    data_d    = '0;
    data_d[0] = v[0];
    for (int i = 1; i < 8; i++) begin
      data_d[i] = word[8] ? (v[i] ^ v[i-1]) : ~(v[i] ^ v[i-1]);
    end

    tok_d = 1'b1;
    c0_d  = 1'b0;
    c1_d  = 1'b0;
    unique case (word)
      CTRL_TOKEN_0: ;
      CTRL_TOKEN_1: c0_d = 1'b1;
      CTRL_TOKEN_2: c1_d = 1'b1;
      CTRL_TOKEN_3: begin
        c0_d = 1'b1;
        c1_d = 1'b1;
      end
      default: tok_d = 1'b0;
    endcase
    if (tok_d) data_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data     <= '0;
      c0       <= 1'b0;
      c1       <= 1'b0;
      is_token <= 1'b0;
    end else begin
      data     <= data_d;
      c0       <= c0_d;
      c1       <= c1_d;
      is_token <= tok_d;
    end
  end

endmodule

// File: rtl/tmds_word_aligner_decoder.sv
// TMDS receive channel: finds the 10-bit word boundary in a free-running deserializer
// stream by barrel-shifting until a run of control tokens is seen, then decodes.
// Ports:
//   paralell_clk in   pixel clock
//   reset_n      in   asynchronous active-low reset
//   raw_data     in   deserialized word, bit0 = first serial bit
//   tmds_data    out  decoded pixel byte (0 unless locked video)
//   tmds_c0/c1   out  control bits, held through video periods
//   tmds_de      out  video data valid
//   locked       out  word alignment achieved
//   bit_offset   out  current barrel-shift offset 0..9
module tmds_word_aligner_decoder
  import tmds_pkg::*;
#(
  parameter int unsigned LOCK_TOKENS  = 8,
  parameter int unsigned SEARCH_DWELL = 4096,
  parameter int unsigned LOSS_TIMEOUT = 8192
) (
  input  logic       paralell_clk,
  input  logic       reset_n,
  input  logic [9:0] raw_data,
  output logic [7:0] tmds_data,
  output logic       tmds_c0,
  output logic       tmds_c1,
  output logic       tmds_de,
  output logic       locked,
  output logic [3:0] bit_offset
);

  localparam int unsigned TokW   = $clog2(LOCK_TOKENS) + 1;
  localparam int unsigned DwellW = $clog2(SEARCH_DWELL) + 1;
  localparam int unsigned LossW  = $clog2(LOSS_TIMEOUT) + 1;

  logic [9:0]        d1_q, d2_q, win_q;
  logic [19:0]       shifted;
  logic [3:0]        offset_q, offset_d;
  state_e            state_q, state_d;
  logic [TokW-1:0]   tok_cnt_q, tok_cnt_d;
  logic [DwellW-1:0] dwell_cnt_q, dwell_cnt_d;
  logic [LossW-1:0]  loss_cnt_q, loss_cnt_d;
  logic              slip_cnt_q, slip_cnt_d;
  logic              tok_hit;
  logic [1:0]        c_hold_q;
  logic [7:0]        dec_data;
  logic              dec_c0, dec_c1, dec_tok;

  // d2 is the older word, so {d1,d2} is the serial stream in order from bit 0.
  assign shifted = {d1_q, d2_q} >> offset_q;

  assign tok_hit = (win_q == CTRL_TOKEN_0) || (win_q == CTRL_TOKEN_1) ||
                   (win_q == CTRL_TOKEN_2) || (win_q == CTRL_TOKEN_3);

  always_ff @(posedge paralell_clk or negedge reset_n) begin
    if (!reset_n) begin
      d1_q  <= '0;
      d2_q  <= '0;
      win_q <= '0;
    end else begin
      d1_q  <= raw_data;
      d2_q  <= d1_q;
      win_q <= shifted[9:0];
    end
  end

  tmds_decode_10b8b u_decode (
    .clk      (paralell_clk),
    .rst_n    (reset_n),
    .word     (win_q),
    .data     (dec_data),
    .c0       (dec_c0),
    .c1       (dec_c1),
    .is_token (dec_tok)
  );

  always_comb begin
    state_d     = state_q;
    offset_d    = offset_q;
    tok_cnt_d   = tok_cnt_q;
    dwell_cnt_d = dwell_cnt_q;
    loss_cnt_d  = loss_cnt_q;
    slip_cnt_d  = 1'b0;
    unique case (state_q)
      SEARCH: begin
        tok_cnt_d   = !tok_hit ? '0 :
                      (&tok_cnt_q) ? tok_cnt_q : tok_cnt_q + 1'b1;
        dwell_cnt_d = (&dwell_cnt_q) ? dwell_cnt_q : dwell_cnt_q + 1'b1;
        if (tok_cnt_d == TokW'(LOCK_TOKENS)) begin
          state_d     = LOCKED;
          tok_cnt_d   = '0;
          dwell_cnt_d = '0;
          loss_cnt_d  = '0;
        end else if (dwell_cnt_q == DwellW'(SEARCH_DWELL - 1)) begin
          state_d     = SLIP;
          offset_d    = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;
          tok_cnt_d   = '0;
          dwell_cnt_d = '0;
        end
      end
      SLIP: begin
        // Two cycles so win_q only holds words taken at the new offset afterwards.
        tok_cnt_d   = '0;
        dwell_cnt_d = '0;
        loss_cnt_d  = '0;
        slip_cnt_d  = 1'b1;
        if (slip_cnt_q) begin
          state_d    = SEARCH;
          slip_cnt_d = 1'b0;
        end
      end
      LOCKED: begin
        loss_cnt_d = tok_hit ? '0 :
                     (&loss_cnt_q) ? loss_cnt_q : loss_cnt_q + 1'b1;
        if (loss_cnt_d == LossW'(LOSS_TIMEOUT)) begin
          state_d     = SEARCH;
          tok_cnt_d   = '0;
          dwell_cnt_d = '0;
          loss_cnt_d  = '0;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  always_ff @(posedge paralell_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= SEARCH;
      offset_q    <= '0;
      tok_cnt_q   <= '0;
      dwell_cnt_q <= '0;
      loss_cnt_q  <= '0;
      slip_cnt_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      offset_q    <= offset_d;
      tok_cnt_q   <= tok_cnt_d;
      dwell_cnt_q <= dwell_cnt_d;
      loss_cnt_q  <= loss_cnt_d;
      slip_cnt_q  <= slip_cnt_d;
    end
  end

  // Control bits persist across video periods; forgotten while unlocked.
  always_ff @(posedge paralell_clk or negedge reset_n) begin
    if (!reset_n) begin
      c_hold_q <= '0;
    end else if (state_q != LOCKED) begin
      c_hold_q <= '0;
    end else if (dec_tok) begin
      c_hold_q <= {dec_c1, dec_c0};
    end
  end

  assign locked     = (state_q == LOCKED);
  assign bit_offset = offset_q;

  always_comb begin
    tmds_de   = 1'b0;
    tmds_data = '0;
    tmds_c0   = 1'b0;
    tmds_c1   = 1'b0;
    if (locked) begin
      if (dec_tok) begin
        tmds_c0 = dec_c0;
        tmds_c1 = dec_c1;
      end else begin
        tmds_de   = 1'b1;
        tmds_data = dec_data;
        tmds_c0   = c_hold_q[0];
        tmds_c1   = c_hold_q[1];
      end
    end
  end

endmodule
